// File: rtl/lsf_event_mux_buffer_if.sv
// rtl/lsf_event_mux_buffer_if.sv - engine-side ROI/hit valid-ready handshake bundle
interface lsf_event_mux_buffer_if #(
    parameter int ROI_W = 24,
    parameter int HIT_W = 16,
    parameter int CH_W  = 2
);
    logic [ROI_W-1:0] o_roi;
    logic             o_roi_valid;
    logic             i_roi_ready;
    logic [HIT_W-1:0] o_hit;
    logic             o_hit_valid;
    logic             i_hit_ready;
    logic             o_hit_last;
    logic [CH_W-1:0]  o_ch;

    modport master (
        output o_roi, o_roi_valid, o_hit, o_hit_valid, o_hit_last, o_ch,
        input  i_roi_ready, i_hit_ready
    );

    modport slave (
        input  o_roi, o_roi_valid, o_hit, o_hit_valid, o_hit_last, o_ch,
        output i_roi_ready, i_hit_ready
    );
endinterface

// File: rtl/lsf_event_mux_buffer.sv
// rtl/lsf_event_mux_buffer.sv - per-channel ROI/hit FIFOs, round-robin event dispatch, spy ring
// Optional LSF_EVT_MUX_OVF_CNT_EN adds saturating per-channel drop counters on o_ovf_cnt.
module lsf_event_mux_buffer #(
    parameter int NUM_CH = 3,
    parameter int HIT_W  = 16,
    parameter int ROI_W  = 24,
    parameter int HIT_AW = 5,
    parameter int ROI_AW = 3,
    parameter int SPY_AW = 10,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CH*ROI_W-1:0]   i_roi,
    input  logic [NUM_CH-1:0]         i_roi_we,
    input  logic [NUM_CH-1:0]         i_roi_nohits,
    input  logic [NUM_CH*HIT_W-1:0]   i_hit,
    input  logic [NUM_CH-1:0]         i_hit_we,
    input  logic [NUM_CH-1:0]         i_hit_last,
    lsf_event_mux_buffer_if.master    eng,
    output logic [NUM_CH-1:0]         o_overflow,
    input  logic                      i_spy_freeze,
    input  logic [SPY_AW-1:0]         i_spy_raddr,
    output logic [HIT_W+CH_W:0]       o_spy_rdata,
    output logic [SPY_AW-1:0]         o_spy_wptr
`ifdef LSF_EVT_MUX_OVF_CNT_EN
    ,
    output logic [NUM_CH*16-1:0]      o_ovf_cnt
`endif
);
    localparam int RD = 1 << ROI_AW;
    localparam int HD = 1 << HIT_AW;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ROI, S_HITS} state_t;

    logic [ROI_W:0]    roi_mem   [NUM_CH][RD];
    logic [HIT_W:0]    hit_mem   [NUM_CH][HD];
    logic [ROI_AW-1:0] roi_wp_q  [NUM_CH];
    logic [ROI_AW-1:0] roi_rp_q  [NUM_CH];
    logic [ROI_AW:0]   roi_cnt_q [NUM_CH];
    logic [HIT_AW-1:0] hit_wp_q  [NUM_CH];
    logic [HIT_AW-1:0] hit_rp_q  [NUM_CH];
    logic [HIT_AW:0]   hit_cnt_q [NUM_CH];

    logic [NUM_CH-1:0] roi_wr, hit_wr, roi_drop, hit_drop, roi_pop, hit_pop;
    logic [NUM_CH-1:0] disc_q, disc_d, ovf_q;
    logic              roi_full, hit_full;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d, rr_q, rr_d, sel, cand, ch_next;
    logic [ROI_W-1:0]  roi_q, roi_d;
    logic              nohits_q, nohits_d, found, hit_avail, hit_valid, hit_acc;
    logic [HIT_W:0]    hit_head;
    int                j;

    logic [HIT_W+CH_W:0] spy_mem [1 << SPY_AW];
    logic [HIT_W+CH_W:0] spy_rdata_q;
    logic [SPY_AW-1:0]   spy_wptr_q;

    // A full FIFO that is being popped this cycle still takes the write.
    always_comb begin
        roi_wr = '0; hit_wr = '0; roi_drop = '0; hit_drop = '0;
        disc_d = disc_q; roi_full = 1'b0; hit_full = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            roi_full = roi_cnt_q[c][ROI_AW] && !roi_pop[c];
            hit_full = hit_cnt_q[c][HIT_AW] && !hit_pop[c];
            if (i_hit_we[c]) begin
                if (disc_q[c]) begin
                    hit_drop[c] = 1'b1;
                    if (i_hit_last[c]) disc_d[c] = 1'b0;
                end else if (hit_full) begin
                    hit_drop[c] = 1'b1;
                    if (!i_hit_last[c]) disc_d[c] = 1'b1;
                end else begin
                    hit_wr[c] = 1'b1;
                end
            end
            // A dropped ROI's hits arrive later, so its discard wins over a same-cycle last.
            if (i_roi_we[c]) begin
                if (roi_full) begin
                    roi_drop[c] = 1'b1;
                    if (!i_roi_nohits[c]) disc_d[c] = 1'b1;
                end else begin
                    roi_wr[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (roi_wr[c]) roi_mem[c][roi_wp_q[c]] <= {i_roi_nohits[c], i_roi[c*ROI_W +: ROI_W]};
            if (hit_wr[c]) hit_mem[c][hit_wp_q[c]] <= {i_hit_last[c], i_hit[c*HIT_W +: HIT_W]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                roi_wp_q[c] <= '0; roi_rp_q[c] <= '0; roi_cnt_q[c] <= '0;
                hit_wp_q[c] <= '0; hit_rp_q[c] <= '0; hit_cnt_q[c] <= '0;
            end
            disc_q <= '0;
            ovf_q  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (roi_wr[c])  roi_wp_q[c] <= roi_wp_q[c] + ROI_AW'(1);
                if (roi_pop[c]) roi_rp_q[c] <= roi_rp_q[c] + ROI_AW'(1);
                if (roi_wr[c] && !roi_pop[c])      roi_cnt_q[c] <= roi_cnt_q[c] + (ROI_AW+1)'(1);
                else if (!roi_wr[c] && roi_pop[c]) roi_cnt_q[c] <= roi_cnt_q[c] - (ROI_AW+1)'(1);
                if (hit_wr[c])  hit_wp_q[c] <= hit_wp_q[c] + HIT_AW'(1);
                if (hit_pop[c]) hit_rp_q[c] <= hit_rp_q[c] + HIT_AW'(1);
                if (hit_wr[c] && !hit_pop[c])      hit_cnt_q[c] <= hit_cnt_q[c] + (HIT_AW+1)'(1);
                else if (!hit_wr[c] && hit_pop[c]) hit_cnt_q[c] <= hit_cnt_q[c] - (HIT_AW+1)'(1);
            end
            disc_q <= disc_d;
            ovf_q  <= ovf_q | roi_drop | hit_drop;
        end
    end

    assign ch_next = (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);

    always_comb begin
        state_d = state_q; ch_d = ch_q; rr_d = rr_q; roi_d = roi_q; nohits_d = nohits_q;
        roi_pop = '0; hit_pop = '0; found = 1'b0; sel = '0; cand = '0; j = 0;
        hit_head  = hit_mem[ch_q][hit_rp_q[ch_q]];
        hit_avail = (hit_cnt_q[ch_q] != '0);
        hit_valid = (state_q == S_HITS) && hit_avail;
        for (int k = 0; k < NUM_CH; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            cand = CH_W'(j);
            if (!found && roi_cnt_q[cand] != '0) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        case (state_q)
            S_IDLE: if (found) begin
                roi_pop[sel]        = 1'b1;
                ch_d                = sel;
                {nohits_d, roi_d}   = roi_mem[sel][roi_rp_q[sel]];
                state_d             = S_ROI;
            end
            S_ROI: if (eng.i_roi_ready) begin
                if (nohits_q) begin
                    state_d = S_IDLE;
                    rr_d    = ch_next;
                end else begin
                    state_d = S_HITS;
                end
            end
            S_HITS: if (hit_valid && eng.i_hit_ready) begin
                hit_pop[ch_q] = 1'b1;
                if (hit_head[HIT_W]) begin
                    state_d = S_IDLE;
                    rr_d    = ch_next;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            rr_q     <= '0;
            roi_q    <= '0;
            nohits_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            rr_q     <= rr_d;
            roi_q    <= roi_d;
            nohits_q <= nohits_d;
        end
    end

    assign hit_acc = hit_valid && eng.i_hit_ready;

    always_ff @(posedge clock) begin
        if (!reset && hit_acc && !i_spy_freeze) spy_mem[spy_wptr_q] <= {hit_head[HIT_W], ch_q, hit_head[HIT_W-1:0]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            spy_wptr_q  <= '0;
            spy_rdata_q <= '0;
        end else begin
            if (hit_acc && !i_spy_freeze) spy_wptr_q <= spy_wptr_q + SPY_AW'(1);
            spy_rdata_q <= spy_mem[i_spy_raddr];
        end
    end

`ifdef LSF_EVT_MUX_OVF_CNT_EN
    logic [15:0] ovf_cnt_q [NUM_CH];
    logic [16:0] ovf_sum   [NUM_CH];

    always_comb begin
        o_ovf_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ovf_sum[c] = {1'b0, ovf_cnt_q[c]} + 17'(roi_drop[c]) + 17'(hit_drop[c]);
            o_ovf_cnt[c*16 +: 16] = ovf_cnt_q[c];
        end
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) ovf_cnt_q[c] <= '0;
            else       ovf_cnt_q[c] <= ovf_sum[c][16] ? 16'hFFFF : ovf_sum[c][15:0];
        end
    end
`endif

    assign eng.o_roi       = roi_q;
    assign eng.o_roi_valid = (state_q == S_ROI);
    assign eng.o_hit       = hit_head[HIT_W-1:0];
    assign eng.o_hit_valid = hit_valid;
    assign eng.o_hit_last  = hit_valid && hit_head[HIT_W];
    assign eng.o_ch        = ch_q;
    assign o_overflow      = ovf_q;
    assign o_spy_rdata     = spy_rdata_q;
    assign o_spy_wptr      = spy_wptr_q;
endmodule
